uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: a 2^FIFO_W-deep byte queue feeding a start/data/[parity]/stop serializer.
// Latency: a write to an empty, idle block makes tx fall at the 2nd rising edge after the write edge.
// Backpressure: tx_full is asserted while the queue holds 2^FIFO_W bytes; a write while full is dropped.
//
// Parameters: clk_freq (Hz), BAUD (bit/s), DBIT (data bits per frame), FIFO_W (queue depth 2^FIFO_W).
// Ports: clk, rst (async, active-low), wr_uart/w_data (push a byte), tx_full/tx_empty (registered
//        queue flags), tx_busy (frame on the line), tx (serial line, idle high, registered).
// Optional feature: define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx #(
    parameter int clk_freq = 50000000,
    parameter int BAUD     = 19200,
    parameter int DBIT     = 8,
    parameter int FIFO_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] w_data,
    output logic            tx_full,
    output logic            tx_empty,
    output logic            tx_busy,
    output logic            tx
);

    // One bit period is 16 ticks of M clocks each.
    localparam int M     = clk_freq / (16 * BAUD);
    localparam int CW    = (M > 1) ? $clog2(M) : 1;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int DEPTH = 1 << FIFO_W;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ------------------------------------------------------------------
    // Byte queue
    // ------------------------------------------------------------------
    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] w_ptr;
    logic [FIFO_W-1:0] r_ptr;
    logic [FIFO_W-1:0] w_ptr_nxt;
    logic [FIFO_W-1:0] r_ptr_nxt;
    logic              wr_en;
    logic              rd_en;
    logic              pop;

    state_t            state;

    // A write while full is dropped even if a pop happens in the same cycle,
    // because both decisions use the registered flags.
    assign wr_en     = wr_uart & ~tx_full;
    assign pop       = (state == IDLE) & ~tx_empty;
    assign rd_en     = pop;
    assign w_ptr_nxt = w_ptr + FIFO_W'(1);
    assign r_ptr_nxt = r_ptr + FIFO_W'(1);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            tx_full  <= 1'b0;
            tx_empty <= 1'b1;
        end else begin
            case ({wr_en, rd_en})
                2'b10: begin
                    w_ptr    <= w_ptr_nxt;
                    tx_empty <= 1'b0;
                    tx_full  <= (w_ptr_nxt == r_ptr);
                end
                2'b01: begin
                    r_ptr    <= r_ptr_nxt;
                    tx_full  <= 1'b0;
                    tx_empty <= (r_ptr_nxt == w_ptr);
                end
                2'b11: begin
                    // Occupancy unchanged; flags stay as they are.
                    w_ptr <= w_ptr_nxt;
                    r_ptr <= r_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    logic [CW-1:0]   tick_cnt;
    logic [3:0]      s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] shreg;
    logic            tick;
`ifdef UART_TX_PARITY_EN
    logic            par;
`endif

    assign tick = (tick_cnt == CW'(M - 1));

    // tx is the registered image of the current state, so it trails the
    // state register by one cycle; tx_busy is registered with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            s_cnt    <= '0;
            n_cnt    <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            // Held at zero in IDLE so every start bit is a full bit period.
            if (state == IDLE || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg   <= mem[r_ptr];
`ifdef UART_TX_PARITY_EN
                        par     <= ^mem[r_ptr];
`endif
                        s_cnt   <= '0;
                        n_cnt   <= '0;
                        state   <= START;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (tick) begin
                        if (s_cnt == 4'd15) begin
                            s_cnt <= '0;
                            state <= DATA;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    tx <= shreg[0];
                    if (tick) begin
                        if (s_cnt == 4'd15) begin
                            s_cnt <= '0;
                            shreg <= shreg >> 1;
                            if (n_cnt == NW'(DBIT - 1)) begin
                                n_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n_cnt <= n_cnt + NW'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx <= par;
                    if (tick) begin
                        if (s_cnt == 4'd15) begin
                            s_cnt <= '0;
                            state <= STOP;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (tick) begin
                        if (s_cnt == 4'd15) begin
                            s_cnt   <= '0;
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx at clk_freq=1600, BAUD=10 (bit period 160 clk).
// The reference model is a frame timeline: each accepted write gets a pop edge
// computed arithmetically, and the expected line level, busy and queue flags are derived from it.
module tb_uart_tx;

    localparam int BITP = 160;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * BITP;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    logic       tx;

    uart_tx #(
        .clk_freq(1600),
        .BAUD    (10),
        .DBIT    (8),
        .FIFO_W  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .tx_full (tx_full),
        .tx_empty(tx_empty),
        .tx_busy (tx_busy),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Timeline model: write edge, pop edge and data of every accepted byte.
    int         w_edge[$];
    int         p_edge[$];
    logic [7:0] f_dat[$];
    logic [7:0] exp_bytes[$];
    int         last_pop = -1000000;

    // Line receiver.
    bit         rx_on = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_b = '0;
    logic [7:0] last_rx = '0;
    logic       prev_tx = 1'b1;
    int         frames = 0;
    int         rx_start[$];
    int         busy_cnt = 0;
`ifdef UART_TX_PARITY_EN
    logic       rx_par = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int occ(input int e);
        int n = 0;
        foreach (w_edge[i]) begin
            if (w_edge[i] <= e) n++;
            if (p_edge[i] <= e) n--;
        end
        return n;
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic exp_tx(input int e);
        logic v = 1'b1;
        foreach (p_edge[i]) begin
            int d = e - p_edge[i];
            if (d >= 1 && d <= FRAME) v = frame_bit(f_dat[i], (d - 1) / BITP);
        end
        return v;
    endfunction

    function automatic logic exp_busy(input int e);
        logic v = 1'b0;
        foreach (p_edge[i]) begin
            int d = e - p_edge[i];
            if (d >= 0 && d < FRAME) v = 1'b1;
        end
        return v;
    endfunction

    // A write at edge w is kept if the queue was not full after edge w-1; it is
    // popped one edge after the write, or one idle edge after the previous frame ends.
    task automatic model_write(input int w, input logic [7:0] b);
        int p;
        if (occ(w - 1) < 4) begin
            p = (w + 1 > last_pop + FRAME + 1) ? w + 1 : last_pop + FRAME + 1;
            w_edge.push_back(w);
            p_edge.push_back(p);
            f_dat.push_back(b);
            exp_bytes.push_back(b);
            last_pop = p;
        end
    endtask

    task automatic model_reset();
        w_edge.delete();
        p_edge.delete();
        f_dat.delete();
        exp_bytes.delete();
        last_pop = -1000000;
        rx_on    = 1'b0;
        prev_tx  = 1'b1;
    endtask

    task automatic receive();
        if (!rx_on) begin
            if (prev_tx === 1'b1 && tx === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
                rx_start.push_back(cyc);
            end
        end else begin
            rx_t++;
        end
        if (rx_on && (rx_t % BITP) == BITP / 2) begin
            int k = rx_t / BITP;
            if (k == 0) begin
                check("rx_start_bit", tx, 0);
            end else if (k <= 8) begin
                rx_b[k-1] = tx;
`ifdef UART_TX_PARITY_EN
            end else if (k == 9) begin
                rx_par = tx;
                check("rx_parity", tx, ^rx_b);
`endif
            end else begin
                check("rx_stop_bit", tx, 1);
                last_rx = rx_b;
                frames++;
                rx_on = 1'b0;
                check("rx_frame_expected", exp_bytes.size() > 0, 1);
                if (exp_bytes.size() > 0) check("rx_data", rx_b, exp_bytes.pop_front());
            end
        end
        prev_tx = tx;
    endtask

    // One clock: drive at the falling edge, compare after the next rising edge.
    task automatic cycle(input logic wr, input logic [7:0] d);
        wr_uart = wr;
        w_data  = d;
        if (wr) model_write(cyc + 1, d);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        wr_uart = 1'b0;
        check("tx", tx, exp_tx(cyc));
        check("tx_busy", tx_busy, exp_busy(cyc));
        check("tx_empty", tx_empty, occ(cyc) == 0);
        check("tx_full", tx_full, occ(cyc) == 4);
        if (tx_busy) busy_cnt++;
        receive();
    endtask

    task automatic drain();
        while (cyc < last_pop + FRAME + 4) cycle(1'b0, 8'h00);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_empty", tx_empty, 1);
        check("rst_full", tx_full, 0);
        model_reset();
        cycle(1'b0, 8'h00);
        rst = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int f0;
        int s0;
        rst     = 1'b0;
        wr_uart = 1'b0;
        w_data  = '0;
        @(posedge clk);
        #1;
        check("reset_tx", tx, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_empty", tx_empty, 1);
        check("reset_full", tx_full, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle(1'b0, 8'h00);

        // Single 0xA5 frame from idle.
        busy_cnt = 0;
        cycle(1'b1, 8'hA5);
        cycle(1'b0, 8'h00);
        check("lat_edge1", tx, 1);
        cycle(1'b0, 8'h00);
        check("lat_edge2", tx, 0);
        drain();
        check("a5_busy_len", busy_cnt, FRAME);
        check("a5_data", last_rx, 8'hA5);
`ifdef UART_TX_PARITY_EN
        check("a5_parity", rx_par, 0);
`endif

        // Four back-to-back writes.
        f0 = frames;
        s0 = rx_start.size();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i));
        check("q4_full", tx_full, occ(cyc) == 4);
        check("q4_not_empty", tx_empty, 0);
        drain();
        check("q4_frames", frames - f0, 4);
        for (int i = 1; i < 4; i++)
            check("q4_gap", rx_start[s0+i] - rx_start[s0+i-1], FRAME + 1);

        // Six writes: the sixth meets a full queue.
        f0 = frames;
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h10 + 8'(i));
        check("q6_full_after5", tx_full, 1);
        cycle(1'b1, 8'h15);
        check("q6_full_after6", tx_full, 1);
        drain();
        check("q6_frames", frames - f0, 5);

        // Reset in the middle of a 0xFF frame with another byte queued.
        cycle(1'b1, 8'hFF);
        w = cyc;
        cycle(1'b1, 8'h3C);
        while (cyc < w + 1 + 800) cycle(1'b0, 8'h00);
        f0 = frames;
        pulse_reset();
        repeat (2000) cycle(1'b0, 8'h00);
        check("rst_no_frames", frames - f0, 0);
        check("rst_flushed", tx_empty, 1);
        cycle(1'b1, 8'h5A);
        cycle(1'b0, 8'h00);
        check("rst_lat1", tx, 1);
        cycle(1'b0, 8'h00);
        check("rst_lat2", tx, 0);
        drain();
        check("rst_fresh_data", last_rx, 8'h5A);

        // Write during the stop bit of the previous frame.
        cycle(1'b1, 8'h81);
        while (cyc < last_pop + FRAME - BITP / 2) cycle(1'b0, 8'h00);
        s0 = rx_start.size();
        cycle(1'b1, 8'h42);
        drain();
        check("stop_wr_gap", rx_start[s0] - rx_start[s0-1], FRAME + 1);
        check("stop_wr_data", last_rx, 8'h42);

`ifdef UART_TX_PARITY_EN
        cycle(1'b1, 8'h07);
        drain();
        check("p07_parity", rx_par, 1);
`endif

        // Random bursts with random spacing.
        for (int b = 0; b < 6; b++) begin
            int n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                cycle(1'b1, 8'($urandom));
                repeat ($urandom_range(0, 2)) cycle(1'b0, 8'h00);
            end
            repeat ($urandom_range(0, 1200)) cycle(1'b0, 8'h00);
        end
        drain();
        check("all_received", exp_bytes.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
